// File: rtl/jt1942_psgmix.sv
// jt1942_psgmix
// Mixes the two 10-bit unsigned PSG outputs of the 1942 sound block into one
// signed 16-bit sample. Each channel is passed through a leaky-integrator
// DC-offset remover, scaled by a 4.4 unsigned gain and summed with
// saturation. The datapath advances only on cen.
//
// Timing: the psg value sampled on cen n reaches snd on cen n+2.
//   stage 1 (cen n)   : capture x_i, update DC estimate est_i / accumulator dc_i
//   stage 2 (cen n+1) : d_i = x_i - est_i, gated by en[i]
//   stage 3 (cen n+2) : snd = sat16(d0*GAIN0 + d1*GAIN1), sample/peak strobes
//
// Ports
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   cen    in   sample clock enable, one-clk pulse (may be held high)
//   en     in   channel enables, bit0 = psg0, bit1 = psg1
//   psg0   in   PSG 0 output, unsigned 10 bit
//   psg1   in   PSG 1 output, unsigned 10 bit
//   snd    out  mixed sample, signed 16 bit
//   sample out  one-clk strobe when snd updates
//   peak   out  one-clk strobe with sample when that sample was clamped

module jt1942_psgmix #(
    parameter logic [7:0] GAIN0 = 8'h10,
    parameter logic [7:0] GAIN1 = 8'h10,
    parameter int         DCSH  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen,
    input  logic [1:0]         en,
    input  logic [9:0]         psg0,
    input  logic [9:0]         psg1,
    output logic signed [15:0] snd,
    output logic               sample,
    output logic               peak
);

    // dc_i holds up to 1023 << DCSH, so 10+DCSH bits never wrap.
    localparam int DCW = 10 + DCSH;

    localparam logic signed [8:0] G0S = {1'b0, GAIN0};
    localparam logic signed [8:0] G1S = {1'b0, GAIN1};

    logic [DCW-1:0]      dc0, dc1;
    logic [9:0]          x0, x1;
    logic [9:0]          est0, est1;
    logic signed [10:0]  d0, d1;
    logic                preloaded;
    logic                v1, v2;

    logic [DCW-1:0]      dc0_nxt, dc1_nxt;
    logic signed [10:0]  d0_raw, d1_raw;
    logic signed [19:0]  p0, p1, sum;
    logic                clip_hi, clip_lo;
    logic signed [15:0]  sat;

    // The intermediate dc + psg may exceed DCW bits, but the final value
    // always fits, so modular arithmetic gives the exact result.
    function automatic logic [DCW-1:0] dc_step(input logic [DCW-1:0] dc,
                                               input logic [9:0]     psg);
        return dc + DCW'(psg) - DCW'(dc[DCW-1:DCSH]);
    endfunction

    always_comb begin
        dc0_nxt = dc_step(dc0, psg0);
        dc1_nxt = dc_step(dc1, psg1);

        d0_raw  = $signed({1'b0, x0}) - $signed({1'b0, est0});
        d1_raw  = $signed({1'b0, x1}) - $signed({1'b0, est1});

        p0      = 20'(d0) * 20'(G0S);
        p1      = 20'(d1) * 20'(G1S);
        sum     = p0 + p1;

        clip_hi = sum > 20'sd32767;
        clip_lo = sum < -20'sd32768;
        sat     = sum[15:0];
        if (clip_hi) begin
            sat = 16'sh7fff;
        end else if (clip_lo) begin
            sat = 16'sh8000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc0       <= '0;
            dc1       <= '0;
            x0        <= '0;
            x1        <= '0;
            est0      <= '0;
            est1      <= '0;
            d0        <= '0;
            d1        <= '0;
            preloaded <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            snd       <= '0;
            sample    <= 1'b0;
            peak      <= 1'b0;
        end else if (cen) begin
            // stage 1
            x0 <= psg0;
            x1 <= psg1;
            if (!preloaded) begin
                // Start the estimator at the current level so the output
                // does not ring out a start-up step.
                dc0  <= {psg0, {DCSH{1'b0}}};
                dc1  <= {psg1, {DCSH{1'b0}}};
                est0 <= psg0;
                est1 <= psg1;
            end else begin
                dc0  <= dc0_nxt;
                dc1  <= dc1_nxt;
                est0 <= dc0[DCW-1:DCSH];
                est1 <= dc1[DCW-1:DCSH];
            end
            preloaded <= 1'b1;

            // stage 2: enable only gates the output, tracking continues
            d0 <= en[0] ? d0_raw : 11'sd0;
            d1 <= en[1] ? d1_raw : 11'sd0;

            // stage 3
            v1     <= 1'b1;
            v2     <= v1;
            sample <= v2;
            peak   <= v2 & (clip_hi | clip_lo);
            if (v2) begin
                snd <= sat;
            end
        end else begin
            sample <= 1'b0;
            peak   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jt1942_psgmix.sv
// Scoreboard bench for jt1942_psgmix. Two instances share all inputs: one with
// unity gains, one with both gains at 8'hFF (to reach saturation). A
// behavioural model pushes the expected snd/peak pair for both instances on
// every cen; a monitor pops on each sample strobe and compares.

module tb_jt1942_psgmix;

    localparam int DCSH = 10;

    logic               clk;
    logic               rst_n;
    logic               cen;
    logic [1:0]         en;
    logic [9:0]         psg0, psg1;
    logic signed [15:0] snd_u, snd_s;
    logic               sample_u, sample_s, peak_u, peak_s;

    jt1942_psgmix #(.GAIN0(8'h10), .GAIN1(8'h10), .DCSH(DCSH)) dut_u (
        .clk(clk), .rst_n(rst_n), .cen(cen), .en(en), .psg0(psg0), .psg1(psg1),
        .snd(snd_u), .sample(sample_u), .peak(peak_u));

    jt1942_psgmix #(.GAIN0(8'hFF), .GAIN1(8'hFF), .DCSH(DCSH)) dut_s (
        .clk(clk), .rst_n(rst_n), .cen(cen), .en(en), .psg0(psg0), .psg1(psg1),
        .snd(snd_s), .sample(sample_s), .peak(peak_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void chk_true(input string name, input bit ok, input int act);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d outside required range", name, act);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int snd_u;
        bit pk_u;
        int snd_s;
        bit pk_s;
    } exp_t;

    exp_t   q[$];
    int     m_cnt;
    bit     m_pre;
    longint m_dc [2];
    int     m_x  [2];
    int     m_est[2];

    function automatic void clampv(input int v, output int o, output bit p);
        p = 1'b0;
        o = v;
        if (v > 32767)  begin o = 32767;  p = 1'b1; end
        if (v < -32768) begin o = -32768; p = 1'b1; end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_cnt = 0;
        m_pre = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_dc[i] = 0; m_x[i] = 0; m_est[i] = 0;
        end
    endfunction

    // Called with the inputs the DUT will see at the coming cen edge.
    function automatic void model_cen();
        int   p[2];
        int   d[2];
        exp_t e;
        p[0] = int'(psg0);
        p[1] = int'(psg1);
        if (m_cnt >= 1) begin
            for (int i = 0; i < 2; i++) d[i] = en[i] ? (m_x[i] - m_est[i]) : 0;
            clampv((d[0] + d[1]) * 16,  e.snd_u, e.pk_u);
            clampv((d[0] + d[1]) * 255, e.snd_s, e.pk_s);
            q.push_back(e);
        end
        for (int i = 0; i < 2; i++) begin
            if (!m_pre) begin
                m_dc[i]  = longint'(p[i]) * (longint'(1) << DCSH);
                m_est[i] = p[i];
            end else begin
                m_est[i] = int'(m_dc[i] / (longint'(1) << DCSH));
                m_dc[i]  = m_dc[i] + p[i] - m_est[i];
            end
            m_x[i] = p[i];
        end
        m_pre = 1'b1;
        m_cnt++;
    endfunction

    // ---------------- monitor ----------------
    int n_samp = 0;
    int last_u = 0;
    int last_s = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_u = 0;
            last_s = 0;
        end else begin
            if (sample_u !== sample_s) begin
                chk("sample_align", int'(sample_s), int'(sample_u));
            end
            if (sample_u === 1'b1) begin
                n_samp++;
                if (q.size() == 0) begin
                    chk("extra_sample", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("snd_u",  int'(snd_u),  e.snd_u);
                    chk("peak_u", int'(peak_u), int'(e.pk_u));
                    chk("snd_s",  int'(snd_s),  e.snd_s);
                    chk("peak_s", int'(peak_s), int'(e.pk_s));
                end
                last_u = int'(snd_u);
                last_s = int'(snd_s);
            end else begin
                if (int'(snd_u) != last_u) chk("glitch_u", int'(snd_u), last_u);
                if (int'(snd_s) != last_s) chk("glitch_s", int'(snd_s), last_s);
                if (peak_u !== 1'b0 || peak_s !== 1'b0)
                    chk("peak_no_sample", int'(peak_u) + int'(peak_s), 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_cen();
        cen = 1'b1;
        model_cen();
        @(posedge clk);
        #1;
        cen = 1'b0;
    endtask

    task automatic run_cens(input int n, input int maxgap);
        for (int k = 0; k < n; k++) begin
            do_cen();
            repeat ($urandom_range(maxgap, 0)) @(posedge clk);
            #0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cen   = 1'b0;
        model_reset();
        n_samp = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int abs_u;
        rst_n = 1'b0;
        cen   = 1'b0;
        en    = 2'b11;
        psg0  = 10'd512;
        psg1  = 10'd512;
        model_reset();
        #12;
        chk("rst_snd_u",    int'(snd_u),    0);
        chk("rst_sample_u", int'(sample_u), 0);
        chk("rst_peak_s",   int'(peak_s),   0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // preload: first strobe on the third cen, all zero
        run_cens(2, 1);
        chk("no_sample_before_3rd", n_samp, 0);
        run_cens(8, 2);
        chk("preload_samples", n_samp, 8);
        chk("preload_snd_u", int'(snd_u), 0);

        // step response on psg0
        en   = 2'b01;
        psg0 = 10'd612;
        do_cen();
        do_cen();
        do_cen();
        chk("step_snd_u", int'(snd_u), 1600);
        chk("step_snd_s", int'(snd_s), 25500);
        chk("step_sample", int'(sample_u), 1);
        run_cens(8 * (1 << DCSH), 1);
        abs_u = (snd_u < 0) ? -int'(snd_u) : int'(snd_u);
        chk_true("step_settled", abs_u < 4, int'(snd_u));

        // enable gating: psg1 steps while disabled
        psg1 = 10'd612;
        run_cens(3, 1);
        abs_u = (snd_u < 0) ? -int'(snd_u) : int'(snd_u);
        chk_true("gated_quiet", abs_u < 4, int'(snd_u));
        run_cens((1 << DCSH) - 3, 1);
        en = 2'b11;
        run_cens(3, 1);
        chk_true("gated_residual", (snd_u > 0) && (snd_u < 1600), int'(snd_u));

        // reset mid-run while snd = 1600
        do_reset();
        psg0 = 10'd512;
        psg1 = 10'd512;
        en   = 2'b01;
        run_cens(4, 1);
        psg0 = 10'd612;
        do_cen();
        do_cen();
        do_cen();
        chk("pre_rst_snd_u", int'(snd_u), 1600);
        rst_n = 1'b0;
        model_reset();
        n_samp = 0;
        #1;
        chk("midrst_snd_u",    int'(snd_u),    0);
        chk("midrst_sample_u", int'(sample_u), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cens(10, 1);
        chk("repreload_snd_u", int'(snd_u), 0);
        chk("repreload_samples", n_samp, 8);

        // positive saturation
        do_reset();
        psg0 = 10'd0;
        psg1 = 10'd0;
        en   = 2'b11;
        run_cens(4, 1);
        psg0 = 10'd1023;
        psg1 = 10'd1023;
        do_cen();
        do_cen();
        do_cen();
        chk("satp_snd_s",  int'(snd_s),  32767);
        chk("satp_peak_s", int'(peak_s), 1);
        chk("satp_snd_u",  int'(snd_u),  32736);
        chk("satp_peak_u", int'(peak_u), 0);

        // negative saturation
        do_reset();
        psg0 = 10'd1023;
        psg1 = 10'd1023;
        run_cens(4, 1);
        psg0 = 10'd0;
        psg1 = 10'd0;
        do_cen();
        do_cen();
        do_cen();
        chk("satn_snd_s",  int'(snd_s),  -32768);
        chk("satn_peak_s", int'(peak_s), 1);
        chk("satn_snd_u",  int'(snd_u),  -32736);
        chk("satn_peak_u", int'(peak_u), 0);

        // random traffic
        do_reset();
        for (int k = 0; k < 400; k++) begin
            psg0 = 10'($urandom_range(1023, 0));
            psg1 = 10'($urandom_range(1023, 0));
            en   = 2'($urandom_range(3, 0));
            do_cen();
            repeat ($urandom_range(2, 0)) @(posedge clk);
            #0;
        end
        @(posedge clk);
        #1;
        chk("queue_pending", q.size(), 1);
        chk("random_samples", n_samp, 398);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
